// File: rtl/lapido_pkg.sv
// Shared types and constants for the Lapido front end (fetch stage and IF/ID register).
package lapido_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR           = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK         = 32'hFFFF_FFFC;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_KEEP  = 2'd0,
    IFID_LOAD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_op_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcpp;
  } fetch_pkt_t;

endpackage

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: load a fetched packet, hold, or flush to a bubble.
module if_id
  import lapido_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset_n,
  input  ifid_op_e        op,
  input  fetch_pkt_t      pkt,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pcpp,
  output logic            valid
);

  // A flush leaves pcpp untouched; only the instruction and valid are cleared.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= NOP_INSTR;
      pcpp        <= '0;
      valid       <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          instruction <= pkt.instr;
          pcpp        <= pkt.pcpp;
          valid       <= 1'b1;
        end
        IFID_FLUSH: begin
          instruction <= NOP_INSTR;
          valid       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Lapido instruction-fetch stage: PC, imem req/ack handshake, stall hold buffer, redirects.
// Optional IF_PERF_COUNTERS_EN adds fetch_count / stall_count outputs.
module if_stage
  import lapido_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pcpp,
  output logic            valid
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
`endif
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  fetch_pkt_t      hold_pkt, hold_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;
  logic            redirect_pending, pend_nxt;
  ifid_op_e        ifid_op;
  fetch_pkt_t      ifid_pkt;
  logic            ack_ok;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] target;

  assign ack_ok    = imem_ack && (state == FETCH);
  assign pc_plus   = pc + PC_INCR;
  assign target    = redirect_target & WORD_MASK;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // State register.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  // Next-state and datapath control; redirect outranks stall.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    hold_nxt        = hold_pkt;
    pend_target_nxt = pend_target;
    pend_nxt        = redirect_pending;
    ifid_op         = IFID_KEEP;
    ifid_pkt        = '{instr: imem_rdata, pcpp: pc_plus};

    if (redirect) begin
      ifid_op   = IFID_FLUSH;
      hold_nxt  = '0;
      state_nxt = FETCH;
      // imem_addr must not move under an outstanding request, so park the target.
      if ((state == FETCH) && !ack_ok) begin
        pend_target_nxt = target;
        pend_nxt        = 1'b1;
      end else begin
        pc_nxt   = target;
        pend_nxt = 1'b0;
      end
    end else if (state == FETCH) begin
      if (!ack_ok) begin
        if (!stall) ifid_op = IFID_FLUSH;
      end else if (redirect_pending) begin
        pc_nxt   = pend_target;
        pend_nxt = 1'b0;
        if (!stall) ifid_op = IFID_FLUSH;
      end else if (!stall) begin
        ifid_op = IFID_LOAD;
        pc_nxt  = pc_plus;
      end else begin
        hold_nxt  = ifid_pkt;
        pc_nxt    = pc_plus;
        state_nxt = HOLD;
      end
    end else begin
      if (!stall) begin
        ifid_op   = IFID_LOAD;
        ifid_pkt  = hold_pkt;
        state_nxt = FETCH;
      end
    end
  end

  // PC, hold buffer and pending-redirect registers.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc               <= RESET_PC;
      hold_pkt         <= '0;
      pend_target      <= '0;
      redirect_pending <= 1'b0;
    end else begin
      pc               <= pc_nxt;
      hold_pkt         <= hold_nxt;
      pend_target      <= pend_target_nxt;
      redirect_pending <= pend_nxt;
    end
  end

  if_id #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clock       (clock),
    .reset_n     (reset_n),
    .op          (ifid_op),
    .pkt         (ifid_pkt),
    .instruction (instruction),
    .pcpp        (pcpp),
    .valid       (valid)
  );

`ifdef IF_PERF_COUNTERS_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ifid_op == IFID_LOAD)  fetch_count <= fetch_count + XLEN'(1);
      if (stall && !redirect)    stall_count <= stall_count + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; a second instance runs with RESET_PC at the top of memory.
module tb_if_stage;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req,    w_req;
  logic [31:0] imem_addr,   w_addr;
  logic [31:0] instruction, w_instr;
  logic [31:0] pcpp,        w_pcpp;
  logic        valid,       w_valid;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

  int checks = 0;
  int fails  = 0;

  if_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .pcpp(pcpp), .valid(valid)
`ifdef IF_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(w_instr),
    .pcpp(w_pcpp), .valid(w_valid)
`ifdef IF_PERF_COUNTERS_EN
    , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_in(input logic st, input logic rd, input logic [31:0] tgt,
                        input logic ack, input logic [31:0] data);
    stall = st; redirect = rd; redirect_target = tgt; imem_ack = ack; imem_rdata = data;
  endtask

  // Advance one falling edge, then sample just after it.
  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset;
    set_in(0, 0, 32'h0, 0, 32'h0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0h want 0", valid); end
    checks++; if (instruction !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 00000000", instruction); end
    checks++; if (pcpp !== 32'h0) begin fails++; $display("FAIL rst_pcpp: got %h want 00000000", pcpp); end
    checks++; if (w_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL rst_w_addr: got %h want fffffffc", w_addr); end
    tick;
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rst_req: got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_fetch;
    set_in(0, 0, 32'h0, 1, 32'h2001_0005);
    tick;
    checks++; if (instruction !== 32'h2001_0005) begin fails++; $display("FAIL f0_instr: got %h want 20010005", instruction); end
    checks++; if (pcpp !== 32'h4) begin fails++; $display("FAIL f0_pcpp: got %h want 00000004", pcpp); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL f0_valid: got %0h want 1", valid); end
    checks++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL f0_addr: got %h want 00000004", imem_addr); end
    set_in(0, 0, 32'h0, 1, 32'h2002_0007);
    tick;
    checks++; if (instruction !== 32'h2002_0007) begin fails++; $display("FAIL f1_instr: got %h want 20020007", instruction); end
    checks++; if (pcpp !== 32'h8) begin fails++; $display("FAIL f1_pcpp: got %h want 00000008", pcpp); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL f1_valid: got %0h want 1", valid); end
    checks++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL f1_addr: got %h want 00000008", imem_addr); end
  endtask

  task automatic test_stall;
    set_in(1, 0, 32'h0, 1, 32'h2003_0009);
    tick;
    checks++; if (instruction !== 32'h2002_0007) begin fails++; $display("FAIL st_hold_instr: got %h want 20020007", instruction); end
    checks++; if (pcpp !== 32'h8) begin fails++; $display("FAIL st_hold_pcpp: got %h want 00000008", pcpp); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL st_req: got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL st_addr: got %h want 0000000c", imem_addr); end
    set_in(1, 0, 32'h0, 1, 32'hDEAD_BEEF);
    tick;
    set_in(1, 0, 32'h0, 0, 32'h0);
    tick;
    checks++; if (instruction !== 32'h2002_0007) begin fails++; $display("FAIL st_hold2_instr: got %h want 20020007", instruction); end
    checks++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL st_stray_addr: got %h want 0000000c", imem_addr); end
    set_in(0, 0, 32'h0, 0, 32'h0);
    tick;
    checks++; if (instruction !== 32'h2003_0009) begin fails++; $display("FAIL st_rel_instr: got %h want 20030009", instruction); end
    checks++; if (pcpp !== 32'hC) begin fails++; $display("FAIL st_rel_pcpp: got %h want 0000000c", pcpp); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL st_rel_valid: got %0h want 1", valid); end
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL st_rel_req: got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL st_rel_addr: got %h want 0000000c", imem_addr); end
  endtask

  task automatic test_redirect_ack;
    set_in(0, 1, 32'h100, 1, 32'h2004_000B);
    tick;
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ra_valid: got %0h want 0", valid); end
    checks++; if (instruction !== 32'h0) begin fails++; $display("FAIL ra_instr: got %h want 00000000", instruction); end
    checks++; if (pcpp !== 32'hC) begin fails++; $display("FAIL ra_pcpp_kept: got %h want 0000000c", pcpp); end
    checks++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL ra_addr: got %h want 00000100", imem_addr); end
    set_in(0, 0, 32'h0, 1, 32'h2005_000D);
    tick;
    checks++; if (instruction !== 32'h2005_000D) begin fails++; $display("FAIL ra_next_instr: got %h want 2005000d", instruction); end
    checks++; if (pcpp !== 32'h104) begin fails++; $display("FAIL ra_next_pcpp: got %h want 00000104", pcpp); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL ra_next_valid: got %0h want 1", valid); end
  endtask

  task automatic test_redirect_pending;
    set_in(0, 1, 32'h40, 0, 32'h0);
    tick;
    checks++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL rp_addr0: got %h want 00000104", imem_addr); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rp_valid0: got %0h want 0", valid); end
    set_in(0, 0, 32'h0, 0, 32'h0);
    tick;
    checks++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL rp_addr1: got %h want 00000104", imem_addr); end
    set_in(0, 0, 32'h0, 1, 32'h2006_000F);
    tick;
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rp_drop_valid: got %0h want 0", valid); end
    checks++; if (instruction !== 32'h0) begin fails++; $display("FAIL rp_drop_instr: got %h want 00000000", instruction); end
    checks++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL rp_addr2: got %h want 00000040", imem_addr); end
    set_in(0, 0, 32'h0, 1, 32'h2007_0011);
    tick;
    checks++; if (instruction !== 32'h2007_0011) begin fails++; $display("FAIL rp_new_instr: got %h want 20070011", instruction); end
    checks++; if (pcpp !== 32'h44) begin fails++; $display("FAIL rp_new_pcpp: got %h want 00000044", pcpp); end
    // A second redirect before the ack replaces the parked target.
    set_in(0, 1, 32'h80, 0, 32'h0);
    tick;
    set_in(0, 1, 32'h200, 0, 32'h0);
    tick;
    checks++; if (imem_addr !== 32'h44) begin fails++; $display("FAIL rp_ow_addr: got %h want 00000044", imem_addr); end
    set_in(0, 0, 32'h0, 1, 32'h1111_1111);
    tick;
    checks++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL rp_ow_target: got %h want 00000200", imem_addr); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rp_ow_valid: got %0h want 0", valid); end
  endtask

  task automatic test_redirect_hold;
    set_in(1, 0, 32'h0, 1, 32'h3333_0000);
    tick;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rh_req0: got %0h want 0", imem_req); end
    set_in(1, 1, 32'h300, 0, 32'h0);
    tick;
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rh_req1: got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h300) begin fails++; $display("FAIL rh_addr: got %h want 00000300", imem_addr); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rh_valid: got %0h want 0", valid); end
    set_in(0, 0, 32'h0, 1, 32'h2008_0019);
    tick;
    checks++; if (instruction !== 32'h2008_0019) begin fails++; $display("FAIL rh_instr: got %h want 20080019", instruction); end
    checks++; if (pcpp !== 32'h304) begin fails++; $display("FAIL rh_pcpp: got %h want 00000304", pcpp); end
  endtask

  task automatic test_wrap;
    set_in(0, 0, 32'h0, 0, 32'h0);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    #1;
    checks++; if (w_req !== 1'b1) begin fails++; $display("FAIL wr_req: got %0h want 1", w_req); end
    set_in(0, 0, 32'h0, 1, 32'h2009_0013);
    tick;
    checks++; if (w_pcpp !== 32'h0) begin fails++; $display("FAIL wr_pcpp: got %h want 00000000", w_pcpp); end
    checks++; if (w_instr !== 32'h2009_0013) begin fails++; $display("FAIL wr_instr: got %h want 20090013", w_instr); end
    checks++; if (w_valid !== 1'b1) begin fails++; $display("FAIL wr_valid: got %0h want 1", w_valid); end
    checks++; if (w_addr !== 32'h0) begin fails++; $display("FAIL wr_addr: got %h want 00000000", w_addr); end
    set_in(0, 1, 32'h103, 1, 32'h0);
    tick;
    checks++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL wr_align: got %h want 00000100", imem_addr); end
    checks++; if (w_addr !== 32'h100) begin fails++; $display("FAIL wr_w_align: got %h want 00000100", w_addr); end
    set_in(0, 0, 32'h0, 1, 32'h200A_0015);
    tick;
    checks++; if (pcpp !== 32'h104) begin fails++; $display("FAIL wr_align_pcpp: got %h want 00000104", pcpp); end
  endtask

`ifdef IF_PERF_COUNTERS_EN
  task automatic test_perf;
    set_in(0, 0, 32'h0, 0, 32'h0);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    checks++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL pc_fetch0: got %0d want 0", fetch_count); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 32'h0, 1, 32'h4000_0000 + 32'(i));
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 32'h0, 0, 32'h0);
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 32'h0, 1, 32'h5000_0000 + 32'(i));
      tick;
    end
    checks++; if (fetch_count !== 32'd5) begin fails++; $display("FAIL pc_fetch: got %0d want 5", fetch_count); end
    checks++; if (stall_count !== 32'd2) begin fails++; $display("FAIL pc_stall: got %0d want 2", stall_count); end
    checks++; if (w_fetch_count !== 32'd5) begin fails++; $display("FAIL pc_w_fetch: got %0d want 5", w_fetch_count); end
    checks++; if (w_stall_count !== 32'd2) begin fails++; $display("FAIL pc_w_stall: got %0d want 2", w_stall_count); end
    set_in(1, 0, 32'h0, 0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (fetch_count !== 32'd0) begin fails++; $display("FAIL pc_rst_fetch: got %0d want 0", fetch_count); end
    checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL pc_rst_stall: got %0d want 0", stall_count); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL pc_rst_valid: got %0h want 0", valid); end
    tick;
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_redirect_ack;
    test_redirect_pending;
    test_redirect_hold;
    test_wrap;
`ifdef IF_PERF_COUNTERS_EN
    test_perf;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the Lapido processor, directly upstream of the decode stage and id_ex.
- Owns the PC and drives a req/ack instruction-memory handshake.
- Presents instruction, pcpp (PC+4) and valid to decode.
- Honours stall from the hazard unit and flush/redirect from branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word presented whenever valid=0.

Ports:
- clock  in  1  stage clock; all state updates on the falling edge, matching the rest of the pipeline
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold IF/ID contents and PC
- redirect  in  1  branch/jump taken; flush IF/ID and load PC from redirect_target
- redirect_target  in  32  new PC; word aligned
- imem_req  out  1  instruction memory request
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack
- imem_ack  in  1  read data valid this cycle; accepted only while imem_req=1
- imem_rdata  in  32  instruction word
- instruction  out  32  IF/ID instruction
- pcpp  out  32  IF/ID PC+4 of that instruction; feeds id_ex pcpp_in
- valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset_n=0, asynchronous): pc=RESET_PC, state=FETCH, instruction=NOP_INSTR, pcpp=0, valid=0, hold buffer cleared, redirect_pending=0. imem_req=1 is combinational from state, so it goes high immediately after reset release.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; an instruction is parked in the hold buffer.
- Priority, per falling edge: reset > redirect > stall > normal.
- FETCH, no ack:
  - If !stall, IF/ID loads a bubble: valid=0, instruction=NOP_INSTR.
  - If stall, IF/ID holds.
  - pc unchanged.
- FETCH, ack, !stall, no redirect_pending:
  - IF/ID loads instruction=imem_rdata, pcpp=pc+4, valid=1.
  - pc<=pc+4; stay in FETCH.
  - Back-to-back acks give 1 instruction/cycle.
- FETCH, ack, stall: imem_rdata and pc+4 go to the hold buffer; pc<=pc+4; go to HOLD. IF/ID is unchanged.
- HOLD, stall: everything holds.
- HOLD, !stall: the hold buffer moves to IF/ID with valid=1; go to FETCH.
- redirect=1, any state:
  - IF/ID: valid=0, instruction=NOP_INSTR, pcpp unchanged. Flush overrides stall.
  - Hold buffer is discarded.
  - pc<=redirect_target.
- Redirect while a request is outstanding (FETCH, no ack this edge):
  - imem_addr must stay stable, so the target goes into a pending register and redirect_pending=1.
  - The next ack's data is dropped (valid stays 0) and pc<=pending target.
  - redirect_pending clears at that edge.
  - A further redirect before that ack overwrites the pending target.
- Redirect coincident with ack in FETCH: the data is dropped; pc<=redirect_target directly, no pending.
- Redirect in HOLD: pc<=redirect_target; go to FETCH.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Low two bits of redirect_target are forced to 0.
- Reset mid-transaction: state is discarded; any later stray ack with imem_req low is ignored.

Optional Feature:
- Macro: IF_PERF_COUNTERS_EN.
- With the macro:
  - Adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0 and wrapping modulo 2^32.
  - fetch_count increments on each edge IF/ID loads valid=1.
  - stall_count increments on each edge with stall=1 and redirect=0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lapido_pkg:
  - fetch-state encoding (FETCH=1'b0, HOLD=1'b1)
  - default RESET_PC constant and NOP_INSTR constant
  - PC_INCR=32'd4
- One sub-module, if_id: the IF/ID output register with load/hold/flush controls.
- The FSM, PC, hold buffer and pending-redirect register stay in if_stage.

Test Plan:
- Reset release, ack every cycle returning 32'h2001_0005, 32'h2002_0007: imem_addr 0, then 4. IF/ID shows (32'h2001_0005, pcpp 4, valid 1), then (32'h2002_0007, pcpp 8, valid 1).
- stall=1 for 3 cycles with ack on the first: IF/ID holds; state HOLD; imem_req=0. On stall release the held word appears with pcpp 12, and the next imem_addr is 12.
- redirect=1, target 32'h0000_0100, coincident with ack: IF/ID valid=0, instruction 0. Next imem_addr 32'h100; the first ack there gives pcpp 32'h104.
- redirect to 32'h40 while ack is delayed 2 cycles: imem_addr stays at the old pc until ack; that data is dropped (valid 0). Next imem_addr is 32'h40.
- RESET_PC=32'hFFFF_FFFC, one ack: pcpp=0; next imem_addr=0. A redirect_target of 32'h0000_0103 is fetched as 32'h100.
- With IF_PERF_COUNTERS_EN, 5 valid fetches and 2 stall cycles: fetch_count=5, stall_count=2. Asserting reset_n=0 mid-sequence clears both and valid asynchronously.
